// File: rtl/rcv_if.sv
// rcv_if: serial receiver line and consumer handshake bundle
interface rcv_if #(
   parameter int DATA_BITS = 8
);
   logic                 serial_in;
   logic                 data_read;
   logic [DATA_BITS-1:0] rx_data;
   logic                 data_ready;
   logic                 framing_error;
   logic                 overrun_error;
   logic                 busy;
   modport slave (
      input  serial_in, data_read,
      output rx_data, data_ready, framing_error, overrun_error, busy
   );
   modport master (
      output serial_in, data_read,
      input  rx_data, data_ready, framing_error, overrun_error, busy
   );
endinterface

// File: rtl/rcv_ctrl.sv
// rcv_ctrl: asynchronous serial frame receiver with framing and overrun flags
module rcv_ctrl #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_BITS    = 8
) (
   input logic  clk,
   input logic  n_rst,
   rcv_if.slave bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_LOAD  = 3'd4;
   localparam int HALF = CLKS_PER_BIT / 2;

   logic [2:0]           r_state;
   logic [7:0]           r_cnt;
   logic [3:0]           r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_prev;
   logic                 r_arm;
   logic                 r_ready;
   logic                 r_ferr;
   logic                 r_ovr;
   logic                 w_half;
   logic                 w_full;
   logic                 w_last_bit;
   logic                 w_start;
   logic                 w_stop_smp;
   logic                 w_good;

   assign w_half     = r_cnt == 8'(HALF - 1);
   assign w_full     = r_cnt == 8'(CLKS_PER_BIT - 1);
   assign w_last_bit = r_bit == 4'(DATA_BITS - 1);
   // r_arm blocks a false edge when the line is already low as reset releases
   assign w_start    = (r_state == S_IDLE) && r_arm && r_prev && !bus.serial_in;
   assign w_stop_smp = (r_state == S_STOP) && w_full;
   assign w_good     = w_stop_smp && bus.serial_in;

   assign bus.rx_data       = r_rx_data;
   assign bus.data_ready    = r_ready;
   assign bus.framing_error = r_ferr;
   assign bus.overrun_error = r_ovr;
   assign bus.busy          = r_state != S_IDLE;

   // frame sequencing: edge detect, mid-bit sampling and data shifting
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_prev  <= 1'b1;
         r_arm   <= 1'b0;
      end else begin
         r_prev <= bus.serial_in;
         r_arm  <= 1'b1;
         case (r_state)
            S_IDLE: if (w_start) begin
               r_state <= S_START;
               r_cnt   <= '0;
            end
            S_START: if (w_half) begin
               r_state <= bus.serial_in ? S_IDLE : S_DATA;
               r_cnt   <= '0;
            end else r_cnt <= r_cnt + 8'd1;
            S_DATA: if (w_full) begin
               r_cnt   <= '0;
               r_shift <= {bus.serial_in, r_shift[DATA_BITS-1:1]};
               r_bit   <= w_last_bit ? 4'd0 : r_bit + 4'd1;
               if (w_last_bit) r_state <= S_STOP;
            end else r_cnt <= r_cnt + 8'd1;
            S_STOP: if (w_full) begin
               r_cnt   <= '0;
               r_state <= S_LOAD;
            end else r_cnt <= r_cnt + 8'd1;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // output word and status flags, updated at the stop sample so they show in LOAD
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_rx_data <= '0;
         r_ready   <= 1'b0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         if (w_start) r_ferr <= 1'b0;
         if (w_good) begin
            r_rx_data <= r_shift;
            r_ready   <= 1'b1;
            r_ferr    <= 1'b0;
            r_ovr     <= r_ready && !bus.data_read;
         end else begin
            if (w_stop_smp) r_ferr <= 1'b1;
            if (bus.data_read) begin
               r_ready <= 1'b0;
               r_ovr   <= 1'b0;
            end
         end
      end
   end
endmodule
